// File: rtl/sv_types_pkg.sv
// Shared types for the HW-side transaction sender: FSM states, header layout
// and the header byte-length helper.
package sv_types_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    HDR     = 2'd1,
    DATA    = 2'd2,
    DISCARD = 2'd3
  } tSenderState;

  localparam logic [7:0] HDR_TYPE_DATA = 8'h01;

  typedef struct packed {
    logic [7:0]  ep_id;
    logic [7:0]  msg_type;
    logic [15:0] byte_len;
    logic [31:0] seq;
  } tSenderHdr;

  // Byte length of a frame whose last word sits at index last_idx.
  function automatic logic [15:0] frame_byte_len(input logic [15:0] last_idx,
                                                 input logic [2:0]  last_drem);
    return {last_idx[12:0], 3'b000} + {13'd0, last_drem} + 16'd1;
  endfunction

endpackage

// File: rtl/hw_sender_buffer.sv
// One-frame store: simple dual-port RAM with one write port and a registered,
// enable-gated read port (read data holds while re is low).
module hw_sender_buffer #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Write port; the array is left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/hw_output_sender.sv
// Store-and-forward sender: collects one DUT output frame, then emits a header
// word (endpoint, type, byte length, sequence) followed by the payload.
module hw_output_sender
  import sv_types_pkg::*;
#(
  parameter int         DATA_WIDTH  = 64,
  parameter logic [7:0] ENDPOINT_ID = 8'h00,
  parameter int         BUF_DEPTH   = 32
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic [2:0]            IN_DREM,
  input  logic                  IN_SOF,
  input  logic                  IN_EOF,
  input  logic                  IN_VLD,
  output logic                  IN_RDY,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output logic [2:0]            OUT_DREM,
  output logic                  OUT_SOF,
  output logic                  OUT_EOF,
  output logic                  OUT_VLD,
  input  logic                  OUT_RDY,
  output logic [31:0]           SEQ_CNT,
  output logic [15:0]           DROP_CNT,
  output logic                  ERR
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BUF_DEPTH);
  localparam logic [AW-1:0] PTR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  tSenderState           state_r, state_s;
  logic [CW-1:0]         wr_cnt_r, wr_cnt_s;
  logic [AW-1:0]         rd_ptr_r, rd_ptr_s;
  logic [AW-1:0]         last_idx_r, last_idx_s;
  logic [AW-1:0]         out_idx_r, out_idx_s;
  logic [2:0]            last_drem_r, last_drem_s;
  logic [DATA_WIDTH-1:0] byp_r, byp_s;
  logic                  byp_sel_r, byp_sel_s;
  logic [DATA_WIDTH-1:0] out_data_r, out_data_s;
  logic [2:0]            out_drem_r, out_drem_s;
  logic                  out_sof_r, out_sof_s;
  logic                  out_eof_r, out_eof_s;
  logic                  out_vld_r, out_vld_s;
  logic                  in_rdy_r, in_rdy_s;
  logic [31:0]           seq_r, seq_s;
  logic [15:0]           drop_r, drop_s;
  logic                  err_r, err_s;

  logic                  we_s, re_s;
  logic [AW-1:0]         waddr_s, raddr_s;
  logic [DATA_WIDTH-1:0] rdata_s;
  logic                  in_acc_s, out_acc_s;
  logic                  drop_ev_s, go_hdr_s;
  logic [AW-1:0]         hdr_idx_s, nxt_idx_s;
  tSenderHdr             hdr_s;

  assign in_acc_s  = IN_VLD && in_rdy_r;
  assign out_acc_s = out_vld_r && OUT_RDY;

  hw_sender_buffer #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (CLK),
    .rst_n (RESET_N),
    .we    (we_s),
    .waddr (waddr_s),
    .wdata (IN_DATA),
    .re    (re_s),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next-state, buffer control and next output values.
  always_comb begin
    state_s     = state_r;
    wr_cnt_s    = wr_cnt_r;
    rd_ptr_s    = rd_ptr_r;
    last_idx_s  = last_idx_r;
    last_drem_s = last_drem_r;
    out_idx_s   = out_idx_r;
    byp_s       = byp_r;
    byp_sel_s   = byp_sel_r;
    out_data_s  = out_data_r;
    out_drem_s  = out_drem_r;
    out_sof_s   = out_sof_r;
    out_eof_s   = out_eof_r;
    out_vld_s   = out_vld_r;
    seq_s       = seq_r;
    drop_s      = drop_r;
    err_s       = err_r;
    we_s        = 1'b0;
    waddr_s     = wr_cnt_r[AW-1:0];
    re_s        = 1'b0;
    raddr_s     = rd_ptr_r;
    drop_ev_s   = 1'b0;
    go_hdr_s    = 1'b0;
    hdr_idx_s   = IN_SOF ? PTR_ZERO : wr_cnt_r[AW-1:0];
    nxt_idx_s   = out_idx_r + PTR_ONE;
    hdr_s.ep_id    = ENDPOINT_ID;
    hdr_s.msg_type = HDR_TYPE_DATA;
    hdr_s.byte_len = frame_byte_len({{(16-AW){1'b0}}, hdr_idx_s}, IN_DREM);
    hdr_s.seq      = seq_r;

    case (state_r)
      COLLECT: begin
        // Keep word 0 staged on the read port so the header handoff has it ready.
        re_s    = 1'b1;
        raddr_s = PTR_ZERO;
        if (in_acc_s) begin
          if (IN_SOF) begin
            drop_ev_s = (wr_cnt_r != CNT_ZERO);
            we_s      = 1'b1;
            waddr_s   = PTR_ZERO;
            go_hdr_s  = IN_EOF;
            wr_cnt_s  = CNT_ONE;
          end else if (wr_cnt_r == CNT_ZERO) begin
            drop_ev_s = 1'b1;
            state_s   = IN_EOF ? COLLECT : DISCARD;
          end else if (wr_cnt_r == CNT_FULL) begin
            drop_ev_s = 1'b1;
            wr_cnt_s  = CNT_ZERO;
            state_s   = IN_EOF ? COLLECT : DISCARD;
          end else begin
            we_s     = 1'b1;
            go_hdr_s = IN_EOF;
            wr_cnt_s = wr_cnt_r + CNT_ONE;
          end
        end else begin
          state_s = COLLECT;
        end
      end
      HDR: begin
        if (out_acc_s) begin
          out_data_s = byp_sel_r ? byp_r : rdata_s;
          out_sof_s  = 1'b0;
          out_idx_s  = PTR_ZERO;
          out_eof_s  = (last_idx_r == PTR_ZERO);
          out_drem_s = (last_idx_r == PTR_ZERO) ? last_drem_r : 3'd7;
          re_s       = 1'b1;
          rd_ptr_s   = rd_ptr_r + PTR_ONE;
          state_s    = DATA;
        end else begin
          state_s = HDR;
        end
      end
      DATA: begin
        if (out_acc_s && out_eof_r) begin
          out_data_s = {DATA_WIDTH{1'b0}};
          out_drem_s = 3'd0;
          out_sof_s  = 1'b0;
          out_eof_s  = 1'b0;
          out_vld_s  = 1'b0;
          seq_s      = seq_r + 32'd1;
          state_s    = COLLECT;
        end else if (out_acc_s) begin
          // rdata already holds the next word; fetch the one after it.
          out_data_s = rdata_s;
          out_idx_s  = nxt_idx_s;
          out_eof_s  = (nxt_idx_s == last_idx_r);
          out_drem_s = (nxt_idx_s == last_idx_r) ? last_drem_r : 3'd7;
          re_s       = 1'b1;
          rd_ptr_s   = rd_ptr_r + PTR_ONE;
        end else begin
          state_s = DATA;
        end
      end
      DISCARD: begin
        if (in_acc_s && IN_EOF) begin
          state_s = COLLECT;
        end else begin
          state_s = DISCARD;
        end
      end
      default: begin
        state_s = COLLECT;
      end
    endcase

    if (go_hdr_s) begin
      // A 1-word frame is written this same edge, so bypass the RAM for it.
      state_s     = HDR;
      wr_cnt_s    = CNT_ZERO;
      last_idx_s  = hdr_idx_s;
      last_drem_s = IN_DREM;
      byp_s       = IN_DATA;
      byp_sel_s   = (hdr_idx_s == PTR_ZERO);
      rd_ptr_s    = PTR_ONE;
      out_data_s  = hdr_s;
      out_drem_s  = 3'd7;
      out_sof_s   = 1'b1;
      out_eof_s   = 1'b0;
      out_vld_s   = 1'b1;
    end else begin
      byp_sel_s = byp_sel_r;
    end

    if (drop_ev_s) begin
      err_s  = 1'b1;
      drop_s = (drop_r == 16'hFFFF) ? drop_r : drop_r + 16'd1;
    end else begin
      err_s = err_r;
    end

    in_rdy_s = (state_s == COLLECT) || (state_s == DISCARD);
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r     <= COLLECT;
      wr_cnt_r    <= CNT_ZERO;
      rd_ptr_r    <= PTR_ZERO;
      last_idx_r  <= PTR_ZERO;
      last_drem_r <= 3'd0;
      out_idx_r   <= PTR_ZERO;
      byp_r       <= {DATA_WIDTH{1'b0}};
      byp_sel_r   <= 1'b0;
      out_data_r  <= {DATA_WIDTH{1'b0}};
      out_drem_r  <= 3'd0;
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      out_vld_r   <= 1'b0;
      in_rdy_r    <= 1'b0;
      seq_r       <= 32'd0;
      drop_r      <= 16'd0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_cnt_r    <= wr_cnt_s;
      rd_ptr_r    <= rd_ptr_s;
      last_idx_r  <= last_idx_s;
      last_drem_r <= last_drem_s;
      out_idx_r   <= out_idx_s;
      byp_r       <= byp_s;
      byp_sel_r   <= byp_sel_s;
      out_data_r  <= out_data_s;
      out_drem_r  <= out_drem_s;
      out_sof_r   <= out_sof_s;
      out_eof_r   <= out_eof_s;
      out_vld_r   <= out_vld_s;
      in_rdy_r    <= in_rdy_s;
      seq_r       <= seq_s;
      drop_r      <= drop_s;
      err_r       <= err_s;
    end
  end

  assign IN_RDY   = in_rdy_r;
  assign OUT_DATA = out_data_r;
  assign OUT_DREM = out_drem_r;
  assign OUT_SOF  = out_sof_r;
  assign OUT_EOF  = out_eof_r;
  assign OUT_VLD  = out_vld_r;
  assign SEQ_CNT  = seq_r;
  assign DROP_CNT = drop_r;
  assign ERR      = err_r;

endmodule
